// File: rtl/ps2_arrow_decoder_if.sv
// rtl/ps2_arrow_decoder_if.sv - PS/2 line inputs and decoded arrow-key outputs
interface ps2_arrow_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [3:0] btnstate;
    logic       byte_valid;
    logic [7:0] scan_byte;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data,
        input  btnstate, byte_valid, scan_byte, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output btnstate, byte_valid, scan_byte, frame_err
    );
endinterface

// File: rtl/ps2_arrow_decoder.sv
// rtl/ps2_arrow_decoder.sv - PS/2 set-2 receiver tracking held arrow keys {up,down,left,right}
module ps2_arrow_decoder #(
    parameter int TIMEOUT_CYC = 20000,
    parameter int TO_W        = 15
) (
    input  logic               clk,
    input  logic               rst,
    ps2_arrow_decoder_if.slave bus
);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_EXT_BRK, S_BRK} state_t;

    logic [1:0]      clk_sync;
    logic [1:0]      data_sync;
    logic            clk_prev;
    logic            fall;
    logic            data_bit;
    logic [3:0]      bit_cnt;
    logic [9:0]      shreg;
    logic [TO_W-1:0] to_cnt;
    logic            byte_valid;
    logic [7:0]      scan_byte;
    logic            frame_err;
    state_t          state_q, state_d;
    logic [3:0]      btn_q, btn_d;
    logic [3:0]      arrow_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], bus.ps2_clk};
            data_sync <= {data_sync[0], bus.ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    assign fall     = clk_prev & ~clk_sync[1];
    assign data_bit = data_sync[1];

    // shreg holds start, d0..d7, parity; the stop bit is checked live on its edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= 4'd0;
            shreg      <= 10'd0;
            to_cnt     <= '0;
            byte_valid <= 1'b0;
            scan_byte  <= 8'd0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                to_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= 4'd0;
                    if (!shreg[0] && (^shreg[9:1]) && data_bit) begin
                        byte_valid <= 1'b1;
                        scan_byte  <= shreg[8:1];
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    shreg[bit_cnt] <= data_bit;
                    bit_cnt        <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                if (to_cnt == TO_MAX) begin
                    bit_cnt <= 4'd0;
                end else begin
                    to_cnt <= to_cnt + TO_W'(1);
                end
            end
        end
    end

    always_comb begin
        arrow_mask = 4'b0000;
        case (scan_byte)
            8'h75:   arrow_mask = 4'b1000;
            8'h72:   arrow_mask = 4'b0100;
            8'h6B:   arrow_mask = 4'b0010;
            8'h74:   arrow_mask = 4'b0001;
            default: arrow_mask = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            btn_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            btn_q   <= btn_d;
        end
    end

    always_comb begin
        state_d = state_q;
        btn_d   = btn_q;
        if (byte_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (scan_byte == 8'hE0) begin
                        state_d = S_EXT;
                    end else if (scan_byte == 8'hF0) begin
                        state_d = S_BRK;
                    end else if (scan_byte == 8'h00 || scan_byte == 8'hFF) begin
                        btn_d = 4'b0000;
                    end
                end
                S_EXT: begin
                    if (scan_byte == 8'hF0) begin
                        state_d = S_EXT_BRK;
                    end else if (scan_byte != 8'hE0) begin
                        btn_d   = btn_q | arrow_mask;
                        state_d = S_IDLE;
                    end
                end
                S_EXT_BRK: begin
                    btn_d   = btn_q & ~arrow_mask;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.btnstate   = btn_q;
    assign bus.byte_valid = byte_valid;
    assign bus.scan_byte  = scan_byte;
    assign bus.frame_err  = frame_err;
endmodule
